// File: rtl/stream_mux_pack.sv
// Stream mux that places one selected narrow word at a byte lane of a wider registered output.
// Build option STREAM_MUX_PACK_SIGN_EXT_EN: fill the bits above the placed field with the word's sign bit.
module stream_mux_pack #(
    parameter int N_CH  = 4,
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16,
    localparam int SEL_W  = $clog2(N_CH),
    localparam int LANE_W = $clog2(OUT_W/8)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*IN_W-1:0]   in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [LANE_W-1:0]      lane,
    output logic [OUT_W-1:0]       out_data,
    output logic [SEL_W-1:0]       out_ch,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       xfer_count
);

    logic             r_valid;
    logic [OUT_W-1:0] r_data;
    logic [SEL_W-1:0] r_ch;
    logic [SEL_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic             w_can_load;
    logic             w_fix_ok;
    logic             w_rr_hit;
    logic             w_gnt_vld;
    logic             w_acc;
    logic [SEL_W-1:0] w_rr_gnt;
    logic [SEL_W-1:0] w_gnt;
    logic [IN_W-1:0]  w_word;
    logic [OUT_W-1:0] w_ext;
    logic [OUT_W-1:0] w_packed;
    int               w_idx;

    assign w_can_load = ~r_valid | out_ready;
    assign w_fix_ok   = (32'(sel) < N_CH);

    // Walk from the pointer upward with wrap; scanning high-to-low leaves the nearest hit last.
    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_gnt = '0;
        w_idx    = 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N_CH)
                w_idx = w_idx - N_CH;
            if (in_valid[w_idx[SEL_W-1:0]]) begin
                w_rr_hit = 1'b1;
                w_rr_gnt = w_idx[SEL_W-1:0];
            end
        end
    end

    assign w_gnt_vld = mode ? w_rr_hit : w_fix_ok;
    assign w_gnt     = mode ? w_rr_gnt : sel;

    always_comb begin
        in_ready = '0;
        for (int c = 0; c < N_CH; c++)
            in_ready[c] = ~rst & w_can_load & w_gnt_vld & (w_gnt == SEL_W'(c));
    end

    assign w_acc = |(in_valid & in_ready);

    always_comb begin
        w_word = '0;
        for (int c = 0; c < N_CH; c++)
            if (w_gnt == SEL_W'(c))
                w_word = in_data[c*IN_W +: IN_W];
    end

`ifdef STREAM_MUX_PACK_SIGN_EXT_EN
    assign w_ext = OUT_W'($signed(w_word));
`else
    assign w_ext = OUT_W'(w_word);
`endif

    // Left shift drops anything pushed past the top byte lane.
    assign w_packed = w_ext << {lane, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_acc) begin
                r_valid <= 1'b1;
                r_data  <= w_packed;
                r_ch    <= w_gnt;
                r_ptr   <= (32'(w_gnt) == N_CH - 1) ? '0 : w_gnt + SEL_W'(1);
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            if (r_valid & out_ready & ~&r_cnt)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_data   = r_data;
    assign out_ch     = r_ch;
    assign out_valid  = r_valid;
    assign xfer_count = r_cnt;

endmodule

// File: tb/tb_stream_mux_pack.sv
// Scoreboard bench for stream_mux_pack: a 4-channel instance plus a 6-channel, 4-bit-counter instance.
module tb_stream_mux_pack;

    localparam bit SX =
`ifdef STREAM_MUX_PACK_SIGN_EXT_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk;
    logic        rst;

    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [1:0]  lane;
    logic [31:0] out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] xfer_count;

    logic [95:0] d6_in_data;
    logic [5:0]  d6_in_valid;
    logic [5:0]  d6_in_ready;
    logic        d6_mode;
    logic [2:0]  d6_sel;
    logic [1:0]  d6_lane;
    logic [31:0] d6_out_data;
    logic [2:0]  d6_out_ch;
    logic        d6_out_valid;
    logic        d6_out_ready;
    logic [3:0]  d6_xfer;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  ch;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_push  = 0;

    stream_mux_pack u_dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel), .lane(lane),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready), .xfer_count(xfer_count)
    );

    stream_mux_pack #(.N_CH(6), .CNT_W(4)) u_dut6 (
        .clk(clk), .rst(rst),
        .in_data(d6_in_data), .in_valid(d6_in_valid), .in_ready(d6_in_ready),
        .mode(d6_mode), .sel(d6_sel), .lane(d6_lane),
        .out_data(d6_out_data), .out_ch(d6_out_ch), .out_valid(d6_out_valid),
        .out_ready(d6_out_ready), .xfer_count(d6_xfer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-by-bit reference placement of a 16-bit word into a 32-bit output.
    function automatic logic [31:0] pack(input logic [15:0] d, input int ln);
        logic [31:0] r;
        int j;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            j = i - ln * 8;
            if (j < 0)       r[i] = 1'b0;
            else if (j < 16) r[i] = d[j[3:0]];
            else             r[i] = SX & d[15];
        end
        return r;
    endfunction

    // Scoreboard: every drained output word must match the oldest expected entry.
    always @(negedge clk) begin
        #2;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_total++;
            if (sbq.size() == 0) begin
                $display("FAIL sb_extra: got data=%h ch=%0d, want no word", out_data, out_ch);
            end else begin
                mon_e = sbq.pop_front();
                if (out_data !== mon_e.d || out_ch !== mon_e.ch)
                    $display("FAIL sb_word: got data=%h ch=%0d, want data=%h ch=%0d",
                             out_data, out_ch, mon_e.d, mon_e.ch);
                else
                    n_pass++;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; in_valid = 4'hF; in_data = 64'h1111_2222_3333_4444;
        mode = 1'b0; sel = 2'd0; lane = 2'd0; out_ready = 1'b1;
        d6_in_data = '0; d6_in_valid = '0; d6_mode = 1'b0; d6_sel = '0;
        d6_lane = '0; d6_out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_total++;
            if (out_valid !== 1'b0 || in_ready !== 4'h0 || xfer_count !== 16'd0)
                $display("FAIL reset_state: got vld=%b rdy=%h cnt=%0d, want 0/0/0",
                         out_valid, in_ready, xfer_count);
            else n_pass++;
        end
        rst = 1'b0; in_valid = 4'b0001; in_data = 64'h0000_0000_0000_00C3;
        n_push = 0;
        #1;
        n_total++;
        if (in_ready !== 4'b0001)
            $display("FAIL reset_first_ready: got %b want 0001", in_ready);
        else n_pass++;
        sbq.push_back('{d: pack(16'h00C3, 0), ch: 2'd0}); n_push++;
        @(negedge clk);
        in_valid = 4'h0;
        #1;
        n_total++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0)
            $display("FAIL reset_first_latency: got vld=%b ch=%0d want 1/0", out_valid, out_ch);
        else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if (out_valid !== 1'b0 || xfer_count !== 16'(n_push))
            $display("FAIL reset_first_drain: got vld=%b cnt=%0d want 0/%0d",
                     out_valid, xfer_count, n_push);
        else n_pass++;
    endtask

    task automatic test_fixed_pack();
        @(negedge clk);
        mode = 1'b0; sel = 2'd2; lane = 2'd1; out_ready = 1'b1;
        in_data = 64'h0000_A5C3_0000_0000; in_valid = 4'b0100;
        #1;
        n_total++;
        if (in_ready !== 4'b0100) $display("FAIL fixed_ready: got %b want 0100", in_ready);
        else n_pass++;
        sbq.push_back('{d: pack(16'hA5C3, 1), ch: 2'd2}); n_push++;
        @(negedge clk);
        in_valid = 4'h0;
        #1;
        n_total++;
        if (out_data !== (SX ? 32'hFFA5C300 : 32'h00A5C300) || out_ch !== 2'd2)
            $display("FAIL fixed_pack: got data=%h ch=%0d want data=%h ch=2",
                     out_data, out_ch, SX ? 32'hFFA5C300 : 32'h00A5C300);
        else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if (xfer_count !== 16'(n_push))
            $display("FAIL fixed_count: got %0d want %0d", xfer_count, n_push);
        else n_pass++;
    endtask

    task automatic test_trunc();
        logic [15:0] td[3];
        logic [1:0]  tl[3];
        logic [31:0] tc[3];
        td = '{16'h1234, 16'h8001, 16'h8001};
        tl = '{2'd3, 2'd0, 2'd2};
        tc = '{32'h3400_0000, SX ? 32'hFFFF_8001 : 32'h0000_8001, 32'h8001_0000};
        @(negedge clk);
        mode = 1'b0; sel = 2'd1; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = '0; in_data[31:16] = td[k]; lane = tl[k]; in_valid = 4'b0010;
            #1;
            n_total++;
            if (in_ready !== 4'b0010) $display("FAIL trunc_ready: got %b want 0010", in_ready);
            else n_pass++;
            if (k > 0) begin
                n_total++;
                if (out_data !== tc[k-1])
                    $display("FAIL trunc_word%0d: got %h want %h", k - 1, out_data, tc[k-1]);
                else n_pass++;
            end
            sbq.push_back('{d: pack(td[k], int'(tl[k])), ch: 2'd1}); n_push++;
            @(negedge clk);
        end
        in_valid = 4'h0;
        #1;
        n_total++;
        if (out_data !== tc[2]) $display("FAIL trunc_word2: got %h want %h", out_data, tc[2]);
        else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if (xfer_count !== 16'(n_push))
            $display("FAIL trunc_count: got %0d want %0d", xfer_count, n_push);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        mode = 1'b0; sel = 2'd0; lane = 2'd0; out_ready = 1'b0;
        in_data = 64'h0000_0000_0000_1111; in_valid = 4'b0001;
        #1;
        n_total++;
        if (in_ready !== 4'b0001) $display("FAIL bp_first_ready: got %b want 0001", in_ready);
        else n_pass++;
        sbq.push_back('{d: pack(16'h1111, 0), ch: 2'd0}); n_push++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_data[15:0] = 16'(16'h2222 + i); lane = 2'd2;
            #1;
            n_total++;
            if (in_ready !== 4'h0 || out_valid !== 1'b1 || out_data !== pack(16'h1111, 0) || out_ch !== 2'd0)
                $display("FAIL bp_hold: got rdy=%b vld=%b data=%h ch=%0d want 0000/1/%h/0",
                         in_ready, out_valid, out_data, out_ch, pack(16'h1111, 0));
            else n_pass++;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            out_ready = 1'b1; in_data[15:0] = 16'(16'h3000 + i);
            #1;
            n_total++;
            if (in_ready !== 4'b0001 || out_valid !== 1'b1)
                $display("FAIL bp_stream: got rdy=%b vld=%b want 0001/1", in_ready, out_valid);
            else n_pass++;
            sbq.push_back('{d: pack(16'(16'h3000 + i), 2), ch: 2'd0}); n_push++;
        end
        @(negedge clk);
        in_valid = 4'h0;
        @(negedge clk); #1;
        n_total++;
        if (out_valid !== 1'b0 || xfer_count !== 16'(n_push))
            $display("FAIL bp_count: got vld=%b cnt=%0d want 0/%0d", out_valid, xfer_count, n_push);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int seq1[5];
        int seq2[4];
        seq1 = '{0, 1, 2, 3, 0};
        seq2 = '{1, 3, 1, 3};
        @(negedge clk);
        rst = 1'b1; in_valid = 4'h0;
        @(negedge clk);
        rst = 1'b0; n_push = 0;
        mode = 1'b1; lane = 2'd0; out_ready = 1'b1; sel = 2'd2;
        in_data = 64'hD003_D002_D001_D000; in_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_total++;
            if (in_ready !== 4'(1 << seq1[k]))
                $display("FAIL rr_all_step%0d: got rdy=%b want ch%0d", k, in_ready, seq1[k]);
            else n_pass++;
            sbq.push_back('{d: pack(16'(16'hD000 + seq1[k]), 0), ch: 2'(seq1[k])}); n_push++;
            @(negedge clk);
        end
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_total++;
            if (in_ready !== 4'(1 << seq2[k]))
                $display("FAIL rr_odd_step%0d: got rdy=%b want ch%0d", k, in_ready, seq2[k]);
            else n_pass++;
            sbq.push_back('{d: pack(16'(16'hD000 + seq2[k]), 0), ch: 2'(seq2[k])}); n_push++;
            @(negedge clk);
        end
        in_valid = 4'h0;
        #1;
        n_total++;
        if (in_ready !== 4'h0) $display("FAIL rr_idle: got rdy=%b want 0000", in_ready);
        else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if (xfer_count !== 16'(n_push))
            $display("FAIL rr_count: got %0d want %0d", xfer_count, n_push);
        else n_pass++;
    endtask

    task automatic test_reset_drop();
        @(negedge clk);
        mode = 1'b0; sel = 2'd1; lane = 2'd0; out_ready = 1'b0;
        in_data = 64'h0000_0000_7777_0000; in_valid = 4'b0010;
        #1;
        n_total++;
        if (in_ready !== 4'b0010) $display("FAIL drop_ready: got %b want 0010", in_ready);
        else n_pass++;
        sbq.push_back('{d: pack(16'h7777, 0), ch: 2'd1});
        @(negedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL drop_held: got vld=%b want 1", out_valid);
        else n_pass++;
        rst = 1'b1; in_valid = 4'hF;
        sbq.delete();
        @(negedge clk); #1;
        n_total++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_ch !== 2'd0 ||
            xfer_count !== 16'd0 || in_ready !== 4'h0)
            $display("FAIL drop_reset: got vld=%b data=%h ch=%0d cnt=%0d rdy=%b want all 0",
                     out_valid, out_data, out_ch, xfer_count, in_ready);
        else n_pass++;
        rst = 1'b0; in_valid = 4'h0; out_ready = 1'b1; n_push = 0;
        @(negedge clk); #1;
        n_total++;
        if (out_valid !== 1'b0 || xfer_count !== 16'd0)
            $display("FAIL drop_after: got vld=%b cnt=%0d want 0/0", out_valid, xfer_count);
        else n_pass++;
    endtask

    task automatic test_sel_boundary();
        @(negedge clk);
        d6_mode = 1'b0; d6_sel = 3'd5; d6_lane = 2'd0; d6_out_ready = 1'b1;
        d6_in_data = '0; d6_in_data[95:80] = 16'hBEEF; d6_in_valid = 6'h3F;
        #1;
        n_total++;
        if (d6_in_ready !== 6'b100000)
            $display("FAIL sel5_ready: got %b want 100000", d6_in_ready);
        else n_pass++;
        @(negedge clk);
        d6_sel = 3'd6;
        #1;
        n_total++;
        if (d6_out_valid !== 1'b1 || d6_out_data !== pack(16'hBEEF, 0) || d6_out_ch !== 3'd5)
            $display("FAIL sel5_word: got vld=%b data=%h ch=%0d want 1/%h/5",
                     d6_out_valid, d6_out_data, d6_out_ch, pack(16'hBEEF, 0));
        else n_pass++;
        n_total++;
        if (d6_in_ready !== 6'h0) $display("FAIL sel6_ready: got %b want 000000", d6_in_ready);
        else n_pass++;
        @(negedge clk);
        d6_sel = 3'd7;
        #1;
        n_total++;
        if (d6_out_valid !== 1'b0 || d6_in_ready !== 6'h0)
            $display("FAIL sel7_nogrant: got vld=%b rdy=%b want 0/000000", d6_out_valid, d6_in_ready);
        else n_pass++;
    endtask

    task automatic test_saturation();
        @(negedge clk);
        d6_in_valid = 6'h0;
        #1;
        n_total++;
        if (d6_xfer !== 4'd1) $display("FAIL sat_start: got %0d want 1", d6_xfer);
        else n_pass++;
        d6_sel = 3'd0; d6_in_valid = 6'h3F; d6_out_ready = 1'b1;
        repeat (20) @(negedge clk);
        d6_in_valid = 6'h0;
        repeat (2) @(negedge clk);
        #1;
        n_total++;
        if (d6_xfer !== 4'd15) $display("FAIL sat_hold: got %0d want 15", d6_xfer);
        else n_pass++;
        d6_in_valid = 6'h3F;
        repeat (5) @(negedge clk);
        d6_in_valid = 6'h0;
        repeat (2) @(negedge clk);
        #1;
        n_total++;
        if (d6_xfer !== 4'd15) $display("FAIL sat_again: got %0d want 15", d6_xfer);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fixed_pack();
        test_trunc();
        test_backpressure();
        test_round_robin();
        test_reset_drop();
        test_sel_boundary();
        test_saturation();
        @(negedge clk); #3;
        n_total++;
        if (sbq.size() != 0) $display("FAIL sb_leftover: got %0d words pending want 0", sbq.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
